// File: rtl/vending_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package     : vending_pkg                                            |
// | Description : Shared types for the vending machine coin paths:       |
// |               coin denomination codes, their face values, and the    |
// |               change_dispenser state encoding.                       |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
package vending_pkg;

   // Denomination codes; the code doubles as the stock/mask bit index.
   typedef enum logic [1:0] {
      D1  = 2'b00,
      D5  = 2'b01,
      D10 = 2'b10,
      D50 = 2'b11
   } denom_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SELECT = 2'd1,
      ISSUE  = 2'd2,
      FINISH = 2'd3
   } cd_state_t;

   // Face value of a denomination in units of 1.
   function automatic logic [5:0] denom_value(input denom_t code);
      logic [5:0] v;
      case (code)
         D1:      v = 6'd1;
         D5:      v = 6'd5;
         D10:     v = 6'd10;
         default: v = 6'd50;
      endcase
      return v;
   endfunction

endpackage
`default_nettype wire

// File: rtl/denom_picker.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : denom_picker                                           |
// | Description : Combinational greedy coin selector. Returns the        |
// |               largest denomination whose value fits in remaining and |
// |               whose mask bit is set (priority 50 > 10 > 5 > 1).      |
// | Ports       : remaining [AMT_W] in  - amount still owed              |
// |               avail     [4]     in  - per-code availability mask     |
// |               hit               out - a denomination was found       |
// |               code      [2]     out - selected denomination code     |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module denom_picker
   import vending_pkg::*;
#(
   parameter int AMT_W = 32
) (
   input  logic [AMT_W-1:0] remaining,
   input  logic [3:0]       avail,
   output logic             hit,
   output denom_t           code
);

   logic w_fit50;
   logic w_fit10;
   logic w_fit5;
   logic w_fit1;

   assign w_fit50 = avail[D50] && (remaining >= AMT_W'(denom_value(D50)));
   assign w_fit10 = avail[D10] && (remaining >= AMT_W'(denom_value(D10)));
   assign w_fit5  = avail[D5]  && (remaining >= AMT_W'(denom_value(D5)));
   assign w_fit1  = avail[D1]  && (remaining != '0);

   always_comb begin
      hit  = 1'b1;
      code = D1;
      if (w_fit50) begin
         code = D50;
      end else if (w_fit10) begin
         code = D10;
      end else if (w_fit5) begin
         code = D5;
      end else if (w_fit1) begin
         code = D1;
      end else begin
         hit = 1'b0;
      end
   end

endmodule
`default_nettype wire

// File: rtl/change_dispenser.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : change_dispenser                                       |
// | Description : Pays out a change amount one coin at a time over a     |
// |               valid/ready handshake, largest denomination first,     |
// |               and reports completion plus any unpaid remainder.      |
// | Build macro : CHANGE_STOCK_EN - per-denomination stock counters with |
// |               refill; without it stock is treated as unlimited, the  |
// |               refill ports are ignored and short is never raised.    |
// | Ports       : clk, reset (async, active-low)                         |
// |               change_valid/change_amount/change_ready - request      |
// |               coin_valid/coin_denom/coin_ready        - hopper side  |
// |               done/short/short_amount                 - completion   |
// |               refill_valid/refill_denom/refill_count  - stock refill |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module change_dispenser
   import vending_pkg::*;
#(
   parameter int AMT_W      = 32,
   parameter int CNT_W      = 8,
   parameter int STOCK_INIT = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             change_valid,
   input  logic [AMT_W-1:0] change_amount,
   output logic             change_ready,
   output logic             coin_valid,
   output logic [1:0]       coin_denom,
   input  logic             coin_ready,
   output logic             done,
   output logic             short,
   output logic [AMT_W-1:0] short_amount,
   input  logic             refill_valid,
   input  logic [1:0]       refill_denom,
   input  logic [CNT_W-1:0] refill_count
);

   cd_state_t        r_state;
   cd_state_t        w_state_nxt;
   logic [AMT_W-1:0] r_remaining;
   denom_t           r_denom;
   logic             w_hit;
   denom_t           w_pick;
   logic [3:0]       w_avail;
   logic             w_coin_take;

   assign w_coin_take  = (r_state == ISSUE) && coin_ready;

   assign change_ready = (r_state == IDLE);
   assign coin_valid   = (r_state == ISSUE);
   assign coin_denom   = r_denom;
   assign done         = (r_state == FINISH);

   denom_picker #(
      .AMT_W (AMT_W)
   ) u_picker (
      .remaining (r_remaining),
      .avail     (w_avail),
      .hit       (w_hit),
      .code      (w_pick)
   );

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // A miss in SELECT covers both "paid in full" (remaining==0) and
   // "out of coins"; the short flag captured below distinguishes them.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (change_valid) w_state_nxt = SELECT;
         SELECT:  w_state_nxt = w_hit ? ISSUE : FINISH;
         ISSUE:   if (coin_ready) w_state_nxt = SELECT;
         default: w_state_nxt = IDLE;
      endcase
   end

   // ----------------------------------------------------------- datapath
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_remaining <= '0;
         r_denom     <= D1;
      end else begin
         case (r_state)
            IDLE: begin
               if (change_valid) r_remaining <= change_amount;
            end
            SELECT: begin
               if (w_hit) r_denom <= w_pick;
            end
            ISSUE: begin
               // The picker only offers coins no larger than remaining.
               if (coin_ready) r_remaining <= r_remaining - AMT_W'(denom_value(r_denom));
            end
            default: ;
         endcase
      end
   end

`ifdef CHANGE_STOCK_EN
   logic             r_short;
   logic [AMT_W-1:0] r_short_amount;

   // Captured on the SELECT miss so the result is valid alongside done
   // and then held until the next request finishes.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_short        <= 1'b0;
         r_short_amount <= '0;
      end else if ((r_state == SELECT) && !w_hit) begin
         r_short        <= (r_remaining != '0);
         r_short_amount <= r_remaining;
      end
   end

   assign short        = r_short;
   assign short_amount = r_short_amount;

   for (genvar gi = 0; gi < 4; gi++) begin : g_stock
      logic [CNT_W-1:0] r_cnt;
      logic [CNT_W:0]   w_sum;
      logic             w_add;
      logic             w_dec;

      // One extra bit catches overflow for saturation. A decrement only
      // happens on a coin that was selected with stock>0, so the sum
      // can never go negative.
      always_comb begin
         w_add = refill_valid && (refill_denom == 2'(gi));
         w_dec = w_coin_take && (r_denom == denom_t'(gi));
         w_sum = {1'b0, r_cnt}
               + (w_add ? {1'b0, refill_count} : {(CNT_W+1){1'b0}})
               - {{CNT_W{1'b0}}, w_dec};
      end

      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            r_cnt <= CNT_W'(STOCK_INIT);
         end else if (w_sum[CNT_W]) begin
            r_cnt <= '1;
         end else begin
            r_cnt <= w_sum[CNT_W-1:0];
         end
      end

      assign w_avail[gi] = (r_cnt != '0);
   end
`else
   // Unlimited stock: every denomination is always available.
   assign w_avail      = 4'b1111;
   assign short        = 1'b0;
   assign short_amount = '0;

   wire w_unused_refill = ^{refill_valid, refill_denom, refill_count,
                            w_coin_take, CNT_W'(STOCK_INIT)};
`endif

endmodule
`default_nettype wire

// File: tb/tb_change_dispenser.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_change_dispenser                                    |
// | Description : Self-checking bench for change_dispenser. A table of   |
// |               requests with hand-computed coin sequences is applied  |
// |               in a loop; reset-state and mid-request reset are       |
// |               checked by hand-written sequences.                     |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module tb_change_dispenser;
   import vending_pkg::*;

   localparam int AMT_W = 32;
   localparam int CNT_W = 8;

   logic             clk;
   logic             reset;
   logic             change_valid;
   logic [AMT_W-1:0] change_amount;
   logic             change_ready;
   logic             coin_valid;
   logic [1:0]       coin_denom;
   logic             coin_ready;
   logic             done;
   logic             short;
   logic [AMT_W-1:0] short_amount;
   logic             refill_valid;
   logic [1:0]       refill_denom;
   logic [CNT_W-1:0] refill_count;

   int errors = 0;
   int checks = 0;

   change_dispenser #(
      .AMT_W      (AMT_W),
      .CNT_W      (CNT_W),
      .STOCK_INIT (3)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .change_valid  (change_valid),
      .change_amount (change_amount),
      .change_ready  (change_ready),
      .coin_valid    (coin_valid),
      .coin_denom    (coin_denom),
      .coin_ready    (coin_ready),
      .done          (done),
      .short         (short),
      .short_amount  (short_amount),
      .refill_valid  (refill_valid),
      .refill_denom  (refill_denom),
      .refill_count  (refill_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic             do_reset;
      int               amount;
      int               stall;
      int               ncoins;
      logic [7:0][1:0]  coins;
      logic             exp_short;
      int               exp_amt;
      logic             refill;
      logic [1:0]       rf_denom;
      int               rf_count;
   } vec_t;

   localparam int NVEC = 8;
   vec_t vecs [NVEC];

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic logic [7:0][1:0] cl(input logic [1:0] c0, input logic [1:0] c1,
                                         input logic [1:0] c2, input logic [1:0] c3,
                                         input logic [1:0] c4, input logic [1:0] c5);
      logic [7:0][1:0] r;
      r    = '0;
      r[0] = c0; r[1] = c1; r[2] = c2; r[3] = c3; r[4] = c4; r[5] = c5;
      return r;
   endfunction

   task automatic do_reset();
      reset = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
   endtask

   // Issues one request and follows it to done. Sampling and driving both
   // happen on the falling edge; cyc counts falling edges after the accept.
   task automatic run_req(input vec_t v, input string tag);
      int   cyc;
      int   got;
      int   last_hs;
      int   stall_left;
      logic fin;

      cyc = 0;
      while (!change_ready && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      chk({tag, "_ready_idle"}, change_ready, 1);

      change_valid  = 1'b1;
      change_amount = AMT_W'(v.amount);
      coin_ready    = 1'b0;
      @(negedge clk);
      change_valid  = 1'b0;
      change_amount = '0;

      cyc        = 1;
      got        = 0;
      last_hs    = 0;
      stall_left = v.stall;
      fin        = 1'b0;
      while (!fin && cyc < 300) begin
         refill_valid = 1'b0;
         if (cyc == 1) begin
            chk({tag, "_ready_low"}, change_ready, 0);
            chk({tag, "_no_early_coin"}, coin_valid, 0);
         end
         if (coin_valid) begin
            if (got >= v.ncoins) begin
               chk({tag, "_extra_coin"}, got, v.ncoins - 1);
               coin_ready = 1'b1;
               got++;
               last_hs = cyc;
            end else if (stall_left > 0) begin
               coin_ready = 1'b0;
               stall_left--;
               chk({tag, "_stall_denom"}, coin_denom, v.coins[got]);
            end else begin
               coin_ready = 1'b1;
               chk({tag, "_coin_denom"}, coin_denom, v.coins[got]);
               if (v.refill && got == 0) begin
                  refill_valid = 1'b1;
                  refill_denom = v.rf_denom;
                  refill_count = CNT_W'(v.rf_count);
               end
               got++;
               last_hs = cyc;
            end
         end else begin
            coin_ready = 1'b0;
         end
         if (done) begin
            fin = 1'b1;
            chk({tag, "_coin_count"}, got, v.ncoins);
            chk({tag, "_short"}, short, v.exp_short);
            chk({tag, "_short_amount"}, short_amount, v.exp_amt);
            chk({tag, "_done_latency"}, cyc, last_hs + 2);
         end
         @(negedge clk);
         cyc++;
      end
      coin_ready   = 1'b0;
      refill_valid = 1'b0;
      chk({tag, "_finished"}, fin, 1);
      chk({tag, "_done_one_cycle"}, done, 0);
      chk({tag, "_back_idle"}, change_ready, 1);
      chk({tag, "_short_amount_held"}, short_amount, v.exp_amt);
   endtask

   initial begin
      reset         = 1'b0;
      change_valid  = 1'b0;
      change_amount = '0;
      coin_ready    = 1'b0;
      refill_valid  = 1'b0;
      refill_denom  = 2'd0;
      refill_count  = '0;

      //          rst   amt  stall n  coins                                exp_s exp_a refill denom cnt
      vecs[0] = '{1'b1, 67,  0,    5, cl(D50, D10, D5, D1, D1, D1),       1'b0, 0,    1'b0,  D1,   0};
      vecs[1] = '{1'b1, 30,  0,    3, cl(D10, D10, D10, D1, D1, D1),      1'b0, 0,    1'b0,  D1,   0};
`ifdef CHANGE_STOCK_EN
      vecs[2] = '{1'b0, 20,  0,    6, cl(D5, D5, D5, D1, D1, D1),         1'b1, 2,    1'b0,  D1,   0};
`else
      vecs[2] = '{1'b0, 20,  0,    2, cl(D10, D10, D1, D1, D1, D1),       1'b0, 0,    1'b0,  D1,   0};
`endif
      vecs[3] = '{1'b1, 15,  5,    2, cl(D10, D5, D1, D1, D1, D1),        1'b0, 0,    1'b0,  D1,   0};
      vecs[4] = '{1'b0, 0,   0,    0, cl(D1, D1, D1, D1, D1, D1),         1'b0, 0,    1'b0,  D1,   0};
      vecs[5] = '{1'b1, 4,   0,    4, cl(D1, D1, D1, D1, D1, D1),         1'b0, 0,    1'b1,  D1,   255};
      vecs[6] = '{1'b0, 6,   0,    2, cl(D5, D1, D1, D1, D1, D1),         1'b0, 0,    1'b0,  D1,   0};
      vecs[7] = '{1'b0, 58,  0,    5, cl(D50, D5, D1, D1, D1, D1),        1'b0, 0,    1'b0,  D1,   0};

      // Reset values, sampled while reset is still asserted and after release.
      @(negedge clk);
      chk("rst_change_ready", change_ready, 1);
      chk("rst_coin_valid", coin_valid, 0);
      chk("rst_coin_denom", coin_denom, 0);
      chk("rst_done", done, 0);
      chk("rst_short", short, 0);
      chk("rst_short_amount", short_amount, 0);
      reset = 1'b1;
      @(negedge clk);
      chk("post_rst_idle", change_ready, 1);

      for (int i = 0; i < NVEC; i++) begin
         if (vecs[i].do_reset) do_reset();
         run_req(vecs[i], $sformatf("v%0d", i));
      end

      // Reset dropped in while the second coin of a 110 request is offered.
      // Stock must revert, so a following 150 request pays three 50s.
      begin
         int   n;
         int   cyc;
         vec_t v;
         do_reset();
         change_valid  = 1'b1;
         change_amount = AMT_W'(110);
         coin_ready    = 1'b1;
         @(negedge clk);
         change_valid  = 1'b0;
         change_amount = '0;
         n   = 0;
         cyc = 0;
         while (n < 2 && cyc < 50) begin
            if (coin_valid) n++;
            if (n < 2) begin
               @(negedge clk);
               cyc++;
            end
         end
         chk("midrst_second_coin_seen", n, 2);
         coin_ready = 1'b0;
         reset      = 1'b0;
         #1;
         chk("midrst_coin_valid", coin_valid, 0);
         chk("midrst_coin_denom", coin_denom, 0);
         chk("midrst_change_ready", change_ready, 1);
         chk("midrst_done", done, 0);
         @(negedge clk);
         reset = 1'b1;
         @(negedge clk);
         chk("midrst_ready_after", change_ready, 1);
         v = '{1'b0, 150, 0, 3, cl(D50, D50, D50, D1, D1, D1), 1'b0, 0, 1'b0, D1, 0};
         run_req(v, "after_midrst");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/change_dispenser.md
# change_dispenser

Outbound coin path of the vending machine: takes a change amount from the purchase FSM and emits coins to the payout hopper one at a time over a valid/ready handshake. Greedy largest-denomination-first selection over 50/10/5/1 coins, with per-denomination stock tracking. Reports completion and any shortfall. It is the counterpart to the coin-accepting front end.

## Interface
- AMT_W, 32: width of change amount and shortfall.
- CNT_W, 8: width of each stock counter and refill count.
- STOCK_INIT, 3: per-denomination stock value loaded at reset.
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low (0 = reset).
- change_valid  in  1  change request valid.
- change_amount  in  AMT_W  amount owed, in units of 1.
- change_ready  out  1  block idle, can accept a request.
- coin_valid  out  1  coin_denom is being offered to the hopper.
- coin_denom  out  2  denomination code (package encoding).
- coin_ready  in  1  hopper takes the coin.
- done  out  1  one-cycle pulse, request finished.
- short  out  1  valid with done; 1 = could not pay in full.
- short_amount  out  AMT_W  unpaid remainder, valid with done, held until next done.
- refill_valid  in  1  add stock.
- refill_denom  in  2  denomination to refill.
- refill_count  in  CNT_W  coins added.

## Operation
- States: IDLE, SELECT, ISSUE, FINISH.
- IDLE: change_ready=1. On change_valid&&change_ready, latch change_amount into remaining, go SELECT.
- SELECT: pick the largest denom with value ≤ remaining and stock>0 (stock check only with the macro). Hit: register denom, go ISSUE. remaining==0: go FINISH with short=0. No hit with remaining>0: go FINISH with short=1.
- ISSUE: coin_valid=1, coin_denom stable. On coin_ready: remaining -= value, stock[denom] -= 1, go SELECT. Without coin_ready, hold (no timeout).
- FINISH: done=1 for one cycle, short/short_amount=remaining registered, go IDLE.
- A request of amount 0 goes IDLE→SELECT→FINISH, with done and short=0 and no coins.
- Refill accepted in any state. stock += refill_count, saturating at 2^CNT_W-1. Same-cycle refill and issue of the same denom: stock + refill_count − 1, saturating.
- Arithmetic: remaining is AMT_W unsigned. Subtraction never underflows, because selection guarantees value ≤ remaining.

## Timing
- Accept at edge T; SELECT during T..T+1; first coin_valid from T+2.
- Per coin: 1 ISSUE cycle (with coin_ready high) + 1 SELECT cycle, so one coin every 2 cycles at best.
- done arrives 2 cycles after the last coin handshake: SELECT, then FINISH.
- change_ready is low from the accept edge until FINISH returns to IDLE.
- Reset values: change_ready=1 (IDLE), coin_valid=0, coin_denom=0, done=0, short=0, short_amount=0, remaining=0, all stock=STOCK_INIT.
- Reset asserted mid-request: outputs take reset values immediately (async), the request is dropped, and stock reverts to STOCK_INIT.

## Configuration
- CHANGE_STOCK_EN defined: stock counters and refill logic are present, and selection requires stock>0, so short can assert.
- CHANGE_STOCK_EN undefined: no counters, and stock is treated as infinite. Refill ports stay on the interface but are ignored. short is always 0 and short_amount is always 0.

## Structure
- Shared package vending_pkg:
  - denom codes D1=2'b00, D5=2'b01, D10=2'b10, D50=2'b11
  - function denom_value(code) returning 1/5/10/50
  - state enum for this block
- Sub-module denom_picker: combinational. Inputs are remaining and a 4-bit available mask. Outputs are hit and code (priority 50>10>5>1).

## Test plan
- Reset, request 67, coin_ready tied 1 → coins 50,10,5,1,1; done with short=0; stock 50/10/5/1 = 2/2/2/1.
- Reset, request 30 → 10,10,10 (stock10=0). Then request 20 → 5,5,5,1,1,1, then done with short=1, short_amount=2.
- Request 15 with coin_ready low for 5 cycles on the first coin → coin_valid and coin_denom=D10 held stable for 5 cycles, no double count; total 10,5.
- Request 0 → no coin_valid, done pulse 2 cycles after accept, short=0.
- Refill D1 count 255 while issuing a D1 (stock 3) → stock saturates at 255.
- reset low during ISSUE of the second coin → coin_valid=0 immediately, change_ready=1 after release, stock=3 for all denominations.
